tiled_matmul_controller: RTL and testbench

Sequencer for the PE-array matrix multiplier that computes C = A x B when the matrices are larger than the PE array. It partitions C into tiles of PE_ROWS x PE_COLS and runs one accumulate / capture / write-back pass per tile. It sits between the host start/done handshake and the datapath: BRAM A/B read ports, PE control, the PE output buffer and the C BRAM write port. It adds C write-port backpressure that the single-tile controller lacks.

---
 rtl/tiled_matmul_controller.sv | 185 ++++++++++++++++++
 tb/tb_tiled_matmul_controller.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tiled_matmul_controller.sv
`default_nettype none
// ============================================================================
// tiled_matmul_controller : tile sequencer for a PE-array C = A x B multiplier
// Optional: MMCTRL_PERF_CNT_EN adds a saturating busy-cycle counter. Rev 1.0
// ============================================================================
module tiled_matmul_controller #(
    parameter int DATA_WIDTH = 16,
    parameter int M          = 4,
    parameter int K          = 3,
    parameter int N          = 4,
    parameter int PE_ROWS    = 2,
    parameter int PE_COLS    = 2,
    localparam int TM = M / PE_ROWS,
    localparam int TN = N / PE_COLS,
    localparam int P  = PE_ROWS * PE_COLS,
    localparam int AW = (TM * K > 1) ? $clog2(TM * K) : 1,
    localparam int BW = (TN * K > 1) ? $clog2(TN * K) : 1,
    localparam int CW = (M * N > 1) ? $clog2(M * N) : 1,
    localparam int PW = (P > 1) ? $clog2(P) : 1,
    localparam int KW = (K > 1) ? $clog2(K) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          a_en,
    output logic          b_en,
    output logic [AW-1:0] a_addr,
    output logic [BW-1:0] b_addr,
    output logic [KW-1:0] k_idx,
    output logic          pe_start,
    output logic          pe_valid,
    output logic          pe_last,
    input  logic [P-1:0]  pe_valid_out,
    output logic          buf_reset,
    output logic          buf_capture,
    output logic [PW-1:0] pe_sel,
    output logic          c_en,
    output logic          c_we,
    output logic [CW-1:0] c_addr,
`ifdef MMCTRL_PERF_CNT_EN
    output logic [31:0]   cycle_count,
`endif
    input  logic          c_ready
);

    localparam int TMW = (TM > 1) ? $clog2(TM) : 1;
    localparam int TNW = (TN > 1) ? $clog2(TN) : 1;

    if (DATA_WIDTH < 1 || K < 1 || (M % PE_ROWS) != 0 || (N % PE_COLS) != 0) begin : g_bad_cfg
        $error("tiled_matmul_controller: illegal matrix / PE array configuration");
    end

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_CLEAR     = 4'd1,
        S_PREFETCH  = 4'd2,
        S_ACCUM     = 4'd3,
        S_WAIT_PE   = 4'd4,
        S_CAPTURE   = 4'd5,
        S_WRITE     = 4'd6,
        S_NEXT_TILE = 4'd7,
        S_DONE      = 4'd8
    } state_t;

    state_t           state_q, state_d;
    logic [KW-1:0]    k_q, k_d;
    logic [PW-1:0]    w_q, w_d;
    logic [TMW-1:0]   tm_q, tm_d;
    logic [TNW-1:0]   tn_q, tn_d;
`ifdef MMCTRL_PERF_CNT_EN
    logic [31:0]      cnt_q, cnt_d;
`endif

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        w_d     = w_q;
        tm_d    = tm_q;
        tn_d    = tn_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_CLEAR;
                    tm_d    = '0;
                    tn_d    = '0;
                end
            end
            S_CLEAR: begin
                k_d     = '0;
                w_d     = '0;
                state_d = S_PREFETCH;
            end
            S_PREFETCH: state_d = S_ACCUM;
            S_ACCUM: begin
                if (k_q == KW'(K - 1)) state_d = S_WAIT_PE;
                else                   k_d     = k_q + KW'(1);
            end
            S_WAIT_PE: begin
                if (&pe_valid_out) state_d = S_CAPTURE;
            end
            S_CAPTURE: state_d = S_WRITE;
            S_WRITE: begin
                // A stalled write keeps w, so the same element is re-presented.
                if (c_ready) begin
                    if (w_q == PW'(P - 1)) state_d = S_NEXT_TILE;
                    else                   w_d     = w_q + PW'(1);
                end
            end
            S_NEXT_TILE: begin
                if (tn_q != TNW'(TN - 1)) begin
                    tn_d    = tn_q + TNW'(1);
                    state_d = S_CLEAR;
                end else if (tm_q != TMW'(TM - 1)) begin
                    tn_d    = '0;
                    tm_d    = tm_q + TMW'(1);
                    state_d = S_CLEAR;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

`ifdef MMCTRL_PERF_CNT_EN
    always_comb begin
        cnt_d = cnt_q;
        if (state_q == S_IDLE) begin
            if (start) cnt_d = '0;
        end else if (cnt_q != 32'hFFFF_FFFF) begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    assign cycle_count = cnt_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            w_q     <= '0;
            tm_q    <= '0;
            tn_q    <= '0;
`ifdef MMCTRL_PERF_CNT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            w_q     <= w_d;
            tm_q    <= tm_d;
            tn_q    <= tn_d;
`ifdef MMCTRL_PERF_CNT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    assign busy        = (state_q != S_IDLE);
    assign done        = (state_q == S_DONE);
    assign pe_valid    = (state_q == S_ACCUM);
    assign pe_start    = pe_valid && (k_q == '0);
    assign pe_last     = pe_valid && (k_q == KW'(K - 1));
    assign k_idx       = pe_valid ? k_q : '0;
    assign buf_reset   = (state_q == S_CLEAR);
    assign buf_capture = (state_q == S_CAPTURE);
    assign c_en        = (state_q == S_WRITE);
    assign c_we        = c_en;

    // During ACCUM the BRAMs are fed one step ahead so data lands with k_idx.
    assign a_en   = (state_q == S_PREFETCH) || (pe_valid && !pe_last);
    assign b_en   = a_en;
    assign a_addr = a_en ? AW'(int'(tm_q) * K + int'(k_q) + (pe_valid ? 1 : 0)) : '0;
    assign b_addr = b_en ? BW'(int'(tn_q) * K + int'(k_q) + (pe_valid ? 1 : 0)) : '0;

    assign pe_sel = c_en ? w_q : '0;
    assign c_addr = c_en ? CW'((int'(tm_q) * PE_ROWS + int'(w_q) / PE_COLS) * N
                               + int'(tn_q) * PE_COLS + int'(w_q) % PE_COLS) : '0;

endmodule
`default_nettype wire

// File: tb/tb_tiled_matmul_controller.sv
`timescale 1ns/1ps
`default_nettype none
// Randomized bench for tiled_matmul_controller: BRAM/PE/C-memory model plus
// expected read/write address streams computed directly from the tiling rules.
module tb_tiled_matmul_controller;

    localparam int M = 4, K = 3, N = 4, PR = 2, PC = 2;
    localparam int TM = M / PR, TN = N / PC, P = PR * PC;
    localparam int AW = 3, BW = 3, CW = 4, PW = 2, KW = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          start, busy, done, a_en, b_en;
    logic [AW-1:0] a_addr;
    logic [BW-1:0] b_addr;
    logic [KW-1:0] k_idx;
    logic          pe_start, pe_valid, pe_last;
    logic [P-1:0]  pe_valid_out;
    logic          buf_reset, buf_capture;
    logic [PW-1:0] pe_sel;
    logic          c_en, c_we, c_ready;
    logic [CW-1:0] c_addr;
`ifdef MMCTRL_PERF_CNT_EN
    logic [31:0]   cycle_count, cycle_count_s;
`endif

    tiled_matmul_controller #(
        .DATA_WIDTH(16), .M(M), .K(K), .N(N), .PE_ROWS(PR), .PE_COLS(PC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .a_en(a_en), .b_en(b_en), .a_addr(a_addr), .b_addr(b_addr), .k_idx(k_idx),
        .pe_start(pe_start), .pe_valid(pe_valid), .pe_last(pe_last),
        .pe_valid_out(pe_valid_out), .buf_reset(buf_reset), .buf_capture(buf_capture),
        .pe_sel(pe_sel), .c_en(c_en), .c_we(c_we), .c_addr(c_addr),
`ifdef MMCTRL_PERF_CNT_EN
        .cycle_count(cycle_count),
`endif
        .c_ready(c_ready)
    );

    // Second instance: K=1, 1x1 PE array, 2x2 matrices.
    logic       start_s, busy_s, done_s, a_en_s, b_en_s;
    logic [0:0] a_addr_s, b_addr_s, k_idx_s, pe_sel_s, pe_valid_out_s;
    logic       pe_start_s, pe_valid_s, pe_last_s, buf_reset_s, buf_capture_s;
    logic       c_en_s, c_we_s, c_ready_s;
    logic [1:0] c_addr_s;

    tiled_matmul_controller #(
        .DATA_WIDTH(8), .M(2), .K(1), .N(2), .PE_ROWS(1), .PE_COLS(1)
    ) dut_s (
        .clk(clk), .rst_n(rst_n), .start(start_s), .busy(busy_s), .done(done_s),
        .a_en(a_en_s), .b_en(b_en_s), .a_addr(a_addr_s), .b_addr(b_addr_s), .k_idx(k_idx_s),
        .pe_start(pe_start_s), .pe_valid(pe_valid_s), .pe_last(pe_last_s),
        .pe_valid_out(pe_valid_out_s), .buf_reset(buf_reset_s), .buf_capture(buf_capture_s),
        .pe_sel(pe_sel_s), .c_en(c_en_s), .c_we(c_we_s), .c_addr(c_addr_s),
`ifdef MMCTRL_PERF_CNT_EN
        .cycle_count(cycle_count_s),
`endif
        .c_ready(c_ready_s)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input longint got, input longint exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    typedef struct packed { int a; int b; } rd_t;
    typedef struct packed { int addr; int sel; } wr_t;

    int  A [M][K];
    int  B [K][N];
    int  Cm [M*N];
    int  acc [PR][PC];
    int  bufm [PR][PC];
    rd_t rdq [$];
    wr_t wrq [$];
    int  first_wr [$];
    int  t3_a [$];
    int  t3_b [$];
    int  prev_a, prev_b, pe_cnt, lsum, stall_cnt, busy_cyc, done_cnt, wr_acc, mode, bp_left;
    bit  prev_rd, mon_en, t1_accum_seen;

    function automatic longint all_outputs();
        return {busy, done, a_en, b_en, a_addr, b_addr, k_idx, pe_start, pe_valid, pe_last,
                buf_reset, buf_capture, pe_sel, c_en, c_we, c_addr};
    endfunction

    task automatic prep_run(input int md);
        rd_t r;
        wr_t w;
        mode = md;
        rdq.delete(); wrq.delete(); first_wr.delete(); t3_a.delete(); t3_b.delete();
        for (int tm = 0; tm < TM; tm++)
            for (int tn = 0; tn < TN; tn++) begin
                for (int k = 0; k < K; k++) begin
                    r.a = tm * K + k; r.b = tn * K + k;
                    rdq.push_back(r);
                end
                for (int e = 0; e < P; e++) begin
                    w.addr = (tm * PR + e / PC) * N + tn * PC + e % PC; w.sel = e;
                    wrq.push_back(w);
                end
            end
        for (int i = 0; i < M; i++)
            for (int k = 0; k < K; k++) A[i][k] = int'($urandom_range(0, 15));
        for (int k = 0; k < K; k++)
            for (int j = 0; j < N; j++) B[k][j] = int'($urandom_range(0, 15));
        for (int i = 0; i < M*N; i++) Cm[i] = -1;
        lsum = 0; stall_cnt = 0; busy_cyc = 0; done_cnt = 0; wr_acc = 0;
        prev_rd = 0; pe_cnt = 0; pe_valid_out = '0; t1_accum_seen = 0;
        bp_left = (md == 1) ? 5 : 0;
    endtask

    task automatic monitor_cycle();
        rd_t r;
        int  prod;
        c_ready = 1'b1;
        if (c_en) begin
            if (mode == 1 && bp_left > 0 && wr_acc == 2) begin
                c_ready = 1'b0;
                bp_left--;
            end else if (mode == 2) begin
                c_ready = ($urandom_range(0, 3) != 0);
            end
        end
        if (busy) busy_cyc++;
        else chk("idle_outputs_zero", all_outputs(), 0);
        if (c_en || c_we) chk("c_we_eq_c_en", c_we, c_en);
        if (a_en || b_en) chk("b_en_eq_a_en", b_en, a_en);
        if (pe_start || pe_last) chk("pe_ctl_needs_valid", pe_valid, 1);

        if (pe_valid) begin
            chk("accum_has_read_data", prev_rd, 1);
            if (prev_rd) begin
                chk("k_idx", k_idx, prev_a % K);
                chk("pe_start_at_k0", pe_start, (prev_a % K) == 0);
                chk("pe_last_at_kmax", pe_last, (prev_a % K) == K - 1);
                for (int rr = 0; rr < PR; rr++)
                    for (int cc = 0; cc < PC; cc++) begin
                        prod = A[(prev_a / K) * PR + rr][prev_a % K] *
                               B[prev_b % K][(prev_b / K) * PC + cc];
                        acc[rr][cc] = pe_start ? prod : acc[rr][cc] + prod;
                    end
            end
            if (wr_acc == P) t1_accum_seen = 1;
            if (pe_last) begin
                pe_cnt = (mode == 2) ? int'($urandom_range(1, 5)) : 3;
                lsum += pe_cnt;
            end
        end else if (pe_cnt > 0) begin
            pe_cnt--;
            if (pe_cnt == 0) pe_valid_out = '1;
        end

        if (a_en) begin
            if (rdq.size() == 0) chk("unexpected_read", rdq.size(), 1);
            else begin
                r = rdq.pop_front();
                chk("a_addr", a_addr, r.a);
                chk("b_addr", b_addr, r.b);
            end
            if (wr_acc / P == 3) begin
                t3_a.push_back(int'(a_addr));
                t3_b.push_back(int'(b_addr));
            end
            prev_a = int'(a_addr); prev_b = int'(b_addr); prev_rd = 1;
        end else begin
            prev_rd = 0;
        end

        if (buf_capture) begin
            bufm = acc;
            pe_valid_out = '0;
        end

        if (c_en) begin
            if (wrq.size() == 0) chk("unexpected_write", wrq.size(), 1);
            else begin
                chk("c_addr", c_addr, wrq[0].addr);
                chk("pe_sel", pe_sel, wrq[0].sel);
                if (c_ready) begin
                    Cm[c_addr] = bufm[pe_sel / PC][pe_sel % PC];
                    if (first_wr.size() < P) first_wr.push_back(int'(c_addr));
                    void'(wrq.pop_front());
                    wr_acc++;
                end else begin
                    stall_cnt++;
                    if (mode == 1) chk("stall_c_addr_held", c_addr, 4);
                end
            end
        end
        if (done) done_cnt++;
    endtask

    initial forever begin
        @(negedge clk);
        if (mon_en) monitor_cycle();
    end

    task automatic do_start();
        if (!start) begin
            @(posedge clk);
            #1 start = 1'b1;
        end
        @(negedge clk);
        chk("busy_before_start_edge", busy, 0);
        @(negedge clk);
        chk("busy_after_start_edge", busy, 1);
        start = 1'b0;
    endtask

    task automatic finish_check(input int lit_cycles);
        int cyc = 0;
        int ref_v;
        while (done_cnt == 0 && cyc < 3000) begin
            @(posedge clk);
            cyc++;
        end
        if (done_cnt == 0) chk("run_timeout_done_seen", done_cnt, 1);
        repeat (3) @(negedge clk);
        #1;
        chk("done_once", done_cnt, 1);
        chk("busy_low_after_done", busy, 0);
        chk("reads_outstanding", rdq.size(), 0);
        chk("writes_outstanding", wrq.size(), 0);
        chk("run_cycles", busy_cyc, TM * TN * (4 + K + P) + lsum + stall_cnt + 1);
        if (lit_cycles >= 0) chk("run_cycles_literal", busy_cyc, lit_cycles);
        for (int i = 0; i < M; i++)
            for (int j = 0; j < N; j++) begin
                ref_v = 0;
                for (int k = 0; k < K; k++) ref_v += A[i][k] * B[k][j];
                chk("c_matrix", Cm[i * N + j], ref_v);
            end
`ifdef MMCTRL_PERF_CNT_EN
        chk("cycle_count", cycle_count, busy_cyc);
        if (lit_cycles >= 0) chk("cycle_count_literal", cycle_count, lit_cycles);
`endif
    endtask

    task automatic run_small();
        int addrs [$];
        int both = 0, dn = 0, cyc = 0, bc = 0;
        @(posedge clk);
        #1 start_s = 1'b1;
        while (dn == 0 && cyc < 300) begin
            @(negedge clk);
            cyc++;
            if (busy_s) begin
                start_s = 1'b0;
                bc++;
            end
            if (pe_valid_s) begin
                chk("k1_start_last_same_cycle", {pe_start_s, pe_last_s}, 3);
                chk("k1_no_next_read", a_en_s, 0);
                both++;
            end
            if (c_en_s) addrs.push_back(int'(c_addr_s));
            if (done_s) dn++;
        end
        chk("k1_done_seen", dn, 1);
        chk("k1_tiles", both, 4);
        chk("k1_writes", addrs.size(), 4);
        for (int i = 0; i < addrs.size() && i < 4; i++) chk("k1_c_addr", addrs[i], i);
        chk("k1_run_cycles", bc, 29);
        @(negedge clk);
        chk("k1_idle_after_done", busy_s, 0);
    endtask

    int lit_w [4] = '{0, 1, 4, 5};
    int lit_r [3] = '{3, 4, 5};

    initial begin
        int cyc;
        start = 1'b0; start_s = 1'b0; c_ready = 1'b1; c_ready_s = 1'b1;
        pe_valid_out = '0; pe_valid_out_s = 1'b1; mon_en = 0; mode = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs_zero", all_outputs(), 0);
        chk("reset_small_busy", {busy_s, done_s, c_en_s, c_addr_s}, 0);
`ifdef MMCTRL_PERF_CNT_EN
        chk("reset_cycle_count", cycle_count, 0);
`endif
        rst_n = 1'b1;

        run_small();

        prep_run(0);
        mon_en = 1;
        do_start();
        finish_check(57);
        chk("tile0_write_count", first_wr.size(), P);
        for (int i = 0; i < first_wr.size() && i < 4; i++) chk("tile0_c_addr_lit", first_wr[i], lit_w[i]);
        chk("tile11_read_count", t3_a.size(), 3);
        for (int i = 0; i < t3_a.size() && i < 3; i++) begin
            chk("tile11_a_addr_lit", t3_a[i], lit_r[i]);
            chk("tile11_b_addr_lit", t3_b[i], lit_r[i]);
        end

        prep_run(1);
        do_start();
        finish_check(62);
        chk("backpressure_stall_cycles", stall_cnt, 5);

        repeat (3) begin
            prep_run(2);
            do_start();
            finish_check(-1);
        end

        prep_run(0);
        do_start();
        cyc = 0;
        while (!t1_accum_seen && cyc < 500) begin
            @(negedge clk);
            cyc++;
        end
        chk("tile1_accum_reached", t1_accum_seen, 1);
        #2;
        chk("busy_before_mid_reset", busy, 1);
        mon_en = 0;
        start = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("mid_reset_outputs_zero", all_outputs(), 0);
`ifdef MMCTRL_PERF_CNT_EN
        chk("mid_reset_cycle_count", cycle_count, 0);
`endif
        repeat (2) @(posedge clk);
        #1;
        prep_run(0);
        rst_n = 1'b1;
        mon_en = 1;
        do_start();
        finish_check(57);
        if (first_wr.size() > 0) chk("restart_first_c_addr", first_wr[0], 0);
        else chk("restart_write_count", first_wr.size(), P);

        mon_en = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete, compared %0d", n_cmp);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
